// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared op encodings, FSM states and operand-signedness helpers
package muldiv_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic {MODE_MUL, MODE_DIV} mode_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : (op != F3_MULHU);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : ~op[1];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the pipeline and the mul/div unit
interface muldiv_seq_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        flush;
    logic        busy;
    logic        res_valid;
    logic [31:0] res;
    logic        div_zero;

    modport master (output start, op, r1, r2, flush, input busy, res_valid, res, div_zero);
    modport slave  (input start, op, r1, r2, flush, output busy, res_valid, res, div_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  mode_t       mode,
    input  logic [63:0] acc,
    input  logic [31:0] b,
    output logic [63:0] acc_next
);
    logic [32:0] sum;
    logic [32:0] diff;

    // multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);
        diff     = acc[63:31] - {1'b0, b};
        acc_next = (mode == MODE_MUL) ? {sum, acc[31:1]}
                 : diff[32]           ? {acc[62:0], 1'b0}
                 :                      {diff[31:0], acc[30:0], 1'b1};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV32M multiply/divide unit, one radix-2 step per cycle
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    state_t      state, state_next;
    logic [4:0]  count;
    logic [63:0] acc, acc_next, prod;
    logic [31:0] b, mag1, mag2, quot, rem, result, res_q, spec_res;
    logic [2:0]  op_q;
    logic        neg, dz, spec, accept, valid;
    logic        neg1, neg2, zero_div, ovf;

    // operand magnitudes and special-case detection on the incoming request
    always_comb begin
        neg1     = rs1_signed(bus.op) & bus.r1[31];
        neg2     = rs2_signed(bus.op) & bus.r2[31];
        mag1     = neg1 ? -bus.r1 : bus.r1;
        mag2     = neg2 ? -bus.r2 : bus.r2;
        zero_div = is_div(bus.op) && bus.r2 == 32'd0;
        ovf      = is_div(bus.op) && !bus.op[0] && bus.r1 == 32'h8000_0000 && bus.r2 == 32'hFFFF_FFFF;
        spec_res = zero_div ? (bus.op[1] ? bus.r1 : 32'hFFFF_FFFF)
                 :            (bus.op[1] ? 32'd0  : 32'h8000_0000);
    end

    // next-state logic; flush kills everything including the accept and the result strobe
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = (zero_div || ovf) ? DONE : CALC;
            end
            CALC: if (count == 5'd31) state_next = DONE;
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            valid      = 1'b0;
        end
        valid = valid & ~rst;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    muldiv_step u_step (
        .mode     (is_div(op_q) ? MODE_DIV : MODE_MUL),
        .acc      (acc),
        .b        (b),
        .acc_next (acc_next)
    );

    // sign fix-up and result selection; special cases carry their answer in acc[31:0]
    always_comb begin
        prod   = neg ? -acc : acc;
        quot   = neg ? -acc[31:0] : acc[31:0];
        rem    = neg ? -acc[63:32] : acc[63:32];
        result = spec           ? acc[31:0]
               : !op_q[2]       ? ((op_q == F3_MUL) ? prod[31:0] : prod[63:32])
               : op_q[1]        ? rem
               :                  quot;
    end

    // datapath: latch request on accept, step while calculating, hold last result
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            b     <= '0;
            op_q  <= '0;
            neg   <= 1'b0;
            dz    <= 1'b0;
            spec  <= 1'b0;
            res_q <= '0;
        end else begin
            if (accept) begin
                count <= '0;
                acc   <= {32'd0, (zero_div || ovf) ? spec_res : mag1};
                b     <= mag2;
                op_q  <= bus.op;
                neg   <= (is_div(bus.op) && bus.op[1]) ? neg1 : neg1 ^ neg2;
                dz    <= zero_div;
                spec  <= zero_div | ovf;
            end else if (state == CALC) begin
                count <= count + 5'd1;
                acc   <= acc_next;
            end
            if (valid) res_q <= result;
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.res_valid = valid;
    assign bus.res       = valid ? result : res_q;
    assign bus.div_zero  = valid & dz;
endmodule
